// File: rtl/orv64_typedef_pkg.sv
// Shared interrupt types: cause codes, mip/mie/mideleg layout,
// fixed priority order, request FSM states and winner picker.
package orv64_typedef_pkg;

  typedef enum logic [3:0] {
    ORV64_INT_U_SW   = 4'd0,
    ORV64_INT_S_SW   = 4'd1,
    ORV64_INT_M_SW   = 4'd3,
    ORV64_INT_U_TIME = 4'd4,
    ORV64_INT_S_TIME = 4'd5,
    ORV64_INT_M_TIME = 4'd7,
    ORV64_INT_U_EXT  = 4'd8,
    ORV64_INT_S_EXT  = 4'd9,
    ORV64_INT_M_EXT  = 4'd11
  } orv64_int_cause_t;

  typedef struct packed {
    logic meip;
    logic rsv10;
    logic seip;
    logic ueip;
    logic mtip;
    logic rsv6;
    logic stip;
    logic utip;
    logic msip;
    logic rsv2;
    logic ssip;
    logic usip;
  } orv64_csr_ideleg_t;

  typedef enum logic [1:0] {
    ORV64_INT_IDLE,
    ORV64_INT_REQ,
    ORV64_INT_ACK
  } orv64_int_state_t;

  localparam int ORV64_INT_NUM = 9;

  // index 0 is the highest priority
  localparam logic [8:0][3:0] ORV64_INT_PRIO = {
    ORV64_INT_U_TIME, ORV64_INT_U_SW, ORV64_INT_U_EXT,
    ORV64_INT_S_TIME, ORV64_INT_S_SW, ORV64_INT_S_EXT,
    ORV64_INT_M_TIME, ORV64_INT_M_SW, ORV64_INT_M_EXT
  };

  function automatic orv64_int_cause_t orv64_int_pick(
    input logic [11:0] elig
  );
    orv64_int_cause_t c;
    c = ORV64_INT_U_SW;
    // lowest first so the highest eligible overwrites
    for (int i = ORV64_INT_NUM - 1; i >= 0; i--) begin
      if (elig[ORV64_INT_PRIO[i]])
        c = orv64_int_cause_t'(ORV64_INT_PRIO[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/orv64_int_sync.sv
// 1-bit flop-chain synchronizer, SYNC_STAGES deep, async active-low reset.
// Ports: clk, rstn, d (async in), q (synchronized out).
module orv64_int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ff <= '0;
    else       ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/orv64_int_req_gen.sv
// Interrupt pending/arbitration and request FSM (IDLE/REQ/ACK).
// Ports: clk, rstn, ext_* lines, csr_mip_sw/mie/mideleg, prv,
// mstatus_mie/sie, int_ready -> int_valid, int_cause, mip_q, wfi_wake.
// Macro ORV64_INT_SYNC_EN: ext lines go through SYNC_STAGES flops.
module orv64_int_req_gen
  import orv64_typedef_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ext_meip,
  input  logic              ext_mtip,
  input  logic              ext_msip,
  input  logic              ext_seip,
  input  orv64_csr_ideleg_t csr_mip_sw,
  input  orv64_csr_ideleg_t csr_mie,
  input  orv64_csr_ideleg_t csr_mideleg,
  input  logic [1:0]        prv,
  input  logic              mstatus_mie,
  input  logic              mstatus_sie,
  input  logic              int_ready,
  output logic              int_valid,
  output orv64_int_cause_t  int_cause,
  output orv64_csr_ideleg_t mip_q,
  output logic              wfi_wake
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("SYNC_STAGES must be 2..4");
  end

  logic meip_s, mtip_s, msip_s, seip_s;

`ifdef ORV64_INT_SYNC_EN
  orv64_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_meip (
    .clk(clk), .rstn(rstn), .d(ext_meip), .q(meip_s));
  orv64_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mtip (
    .clk(clk), .rstn(rstn), .d(ext_mtip), .q(mtip_s));
  orv64_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_msip (
    .clk(clk), .rstn(rstn), .d(ext_msip), .q(msip_s));
  orv64_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_seip (
    .clk(clk), .rstn(rstn), .d(ext_seip), .q(seip_s));
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meip_s <= 1'b0;
      mtip_s <= 1'b0;
      msip_s <= 1'b0;
      seip_s <= 1'b0;
    end else begin
      meip_s <= ext_meip;
      mtip_s <= ext_mtip;
      msip_s <= ext_msip;
      seip_s <= ext_seip;
    end
  end
`endif

  logic usip_q, ssip_q, utip_q, stip_q, ueip_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      usip_q <= 1'b0;
      ssip_q <= 1'b0;
      utip_q <= 1'b0;
      stip_q <= 1'b0;
      ueip_q <= 1'b0;
    end else begin
      usip_q <= csr_mip_sw.usip;
      ssip_q <= csr_mip_sw.ssip;
      utip_q <= csr_mip_sw.utip;
      stip_q <= csr_mip_sw.stip;
      ueip_q <= csr_mip_sw.ueip;
    end
  end

  // hardware-owned fields of the sw vector are ignored
  logic unused_sw;
  assign unused_sw = ^{csr_mip_sw.meip, csr_mip_sw.rsv10,
                       csr_mip_sw.seip, csr_mip_sw.mtip,
                       csr_mip_sw.rsv6, csr_mip_sw.msip,
                       csr_mip_sw.rsv2};

  always_comb begin
    mip_q      = '0;
    mip_q.meip = meip_s;
    mip_q.mtip = mtip_s;
    mip_q.msip = msip_s;
    mip_q.seip = seip_s;
    mip_q.usip = usip_q;
    mip_q.ssip = ssip_q;
    mip_q.utip = utip_q;
    mip_q.stip = stip_q;
    mip_q.ueip = ueip_q;
  end

  logic        m_en, s_en, any_elig;
  logic [11:0] pend, ie, dl, elig;

  assign m_en = (prv != 2'd3) | mstatus_mie;
  assign s_en = (prv == 2'd0) | ((prv == 2'd1) & mstatus_sie);

  assign pend = mip_q;
  assign ie   = csr_mie;
  assign dl   = csr_mideleg;
  assign elig = pend & ie &
                ((~dl & {12{m_en}}) | (dl & {12{s_en}}));

  assign any_elig = |elig;
  assign wfi_wake = |(pend & ie);

  orv64_int_state_t state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ORV64_INT_IDLE;
      int_valid <= 1'b0;
      int_cause <= ORV64_INT_U_SW;
    end else begin
      unique case (state)
        ORV64_INT_IDLE: begin
          if (any_elig) begin
            state     <= ORV64_INT_REQ;
            int_valid <= 1'b1;
            int_cause <= orv64_int_pick(elig);
          end
        end
        ORV64_INT_REQ: begin
          // an accept wins over a same-cycle withdraw
          if (int_ready) begin
            state     <= ORV64_INT_ACK;
            int_valid <= 1'b0;
          end else if (!elig[int_cause]) begin
            state     <= ORV64_INT_IDLE;
            int_valid <= 1'b0;
          end
        end
        ORV64_INT_ACK: begin
          state <= ORV64_INT_IDLE;
        end
        default: begin
          state     <= ORV64_INT_IDLE;
          int_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_orv64_int_req_gen.sv
// Directed self-checking bench for orv64_int_req_gen.
// Latency constants follow ORV64_INT_SYNC_EN when it is defined.
module tb_orv64_int_req_gen;
  import orv64_typedef_pkg::*;

  localparam int SS = 3;
`ifdef ORV64_INT_SYNC_EN
  localparam int LAT = SS;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              rstn;
  logic              ext_meip, ext_mtip, ext_msip, ext_seip;
  orv64_csr_ideleg_t csr_mip_sw, csr_mie, csr_mideleg;
  logic [1:0]        prv;
  logic              mstatus_mie, mstatus_sie;
  logic              int_ready;
  logic              int_valid;
  orv64_int_cause_t  int_cause;
  orv64_csr_ideleg_t mip_q;
  logic              wfi_wake;

  int n_chk = 0;
  int n_err = 0;

  orv64_int_req_gen #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rstn(rstn),
    .ext_meip(ext_meip), .ext_mtip(ext_mtip),
    .ext_msip(ext_msip), .ext_seip(ext_seip),
    .csr_mip_sw(csr_mip_sw), .csr_mie(csr_mie),
    .csr_mideleg(csr_mideleg), .prv(prv),
    .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie),
    .int_ready(int_ready), .int_valid(int_valid),
    .int_cause(int_cause), .mip_q(mip_q),
    .wfi_wake(wfi_wake)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn        = 1'b0;
    ext_meip    = 1'b0;
    ext_mtip    = 1'b0;
    ext_msip    = 1'b0;
    ext_seip    = 1'b0;
    csr_mip_sw  = '0;
    csr_mie     = '0;
    csr_mideleg = '0;
    prv         = 2'd0;
    mstatus_mie = 1'b0;
    mstatus_sie = 1'b0;
    int_ready   = 1'b0;
    repeat (2) tick;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1;
    ext_meip = 0; ext_mtip = 0; ext_msip = 0; ext_seip = 0;
    csr_mip_sw = '0; csr_mie = '0; csr_mideleg = '0;
    prv = 0; mstatus_mie = 0; mstatus_sie = 0; int_ready = 0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_valid", int_valid, 0);
    chk("rst_cause", int_cause, ORV64_INT_U_SW);
    chk("rst_mip", mip_q, 0);
    chk("rst_wfi", wfi_wake, 0);

    // M external at prv=3, plus accept/ACK/re-arbitration
    do_reset;
    prv = 3; mstatus_mie = 1; csr_mie.meip = 1; ext_meip = 1;
    repeat (LAT) tick;
    chk("meip_mip", mip_q.meip, 1);
    chk("meip_early", int_valid, 0);
    tick;
    chk("meip_valid", int_valid, 1);
    chk("meip_cause", int_cause, ORV64_INT_M_EXT);
    chk("meip_wfi", wfi_wake, 1);
    int_ready = 1;
    tick;
    chk("meip_acc", int_valid, 0);
    int_ready = 0;
    tick;
    chk("meip_ackcyc", int_valid, 0);
    tick;
    chk("meip_rearb", int_valid, 1);

    // MTI beats delegated SEI, then SEI after handshake
    do_reset;
    prv = 0; ext_mtip = 1; ext_seip = 1;
    csr_mie.mtip = 1; csr_mie.seip = 1; csr_mideleg.seip = 1;
    repeat (LAT + 1) tick;
    chk("mti_valid", int_valid, 1);
    chk("mti_cause", int_cause, ORV64_INT_M_TIME);
    int_ready = 1; csr_mie.mtip = 0;
    tick;
    chk("mti_acc", int_valid, 0);
    int_ready = 0;
    tick;
    chk("mti_ackcyc", int_valid, 0);
    tick;
    chk("sei_valid", int_valid, 1);
    chk("sei_cause", int_cause, ORV64_INT_S_EXT);

    // withdraw on lost eligibility; ready wins over withdraw
    do_reset;
    prv = 1; mstatus_sie = 1;
    csr_mip_sw.ssip = 1; csr_mie.ssip = 1; csr_mideleg.ssip = 1;
    tick; tick;
    chk("ssi_valid", int_valid, 1);
    chk("ssi_cause", int_cause, ORV64_INT_S_SW);
    mstatus_sie = 0;
    tick;
    chk("wd_valid", int_valid, 0);
    tick;
    chk("wd_hold", int_valid, 0);
    mstatus_sie = 1;
    tick;
    chk("wd_idle_req", int_valid, 1);
    mstatus_sie = 0; int_ready = 1;
    tick;
    chk("rdy_win", int_valid, 0);
    mstatus_sie = 1; int_ready = 0;
    tick;
    chk("rdy_ackcyc", int_valid, 0);
    tick;
    chk("rdy_rearb", int_valid, 1);

    // latched cause stable against higher-priority arrival
    do_reset;
    prv = 1; mstatus_sie = 1;
    csr_mip_sw.ssip = 1; csr_mie.ssip = 1; csr_mideleg.ssip = 1;
    tick; tick;
    chk("stab_pre", int_cause, ORV64_INT_S_SW);
    ext_meip = 1; csr_mie.meip = 1;
    repeat (LAT + 2) tick;
    chk("stab_valid", int_valid, 1);
    chk("stab_cause", int_cause, ORV64_INT_S_SW);
    int_ready = 1;
    tick;
    chk("stab_acc", int_valid, 0);
    int_ready = 0;
    tick; tick;
    chk("stab_next", int_valid, 1);
    chk("stab_mei", int_cause, ORV64_INT_M_EXT);

    // sw-vector masking, wfi_wake without global enable
    do_reset;
    prv = 3; mstatus_mie = 0;
    csr_mip_sw = '1; csr_mie.ssip = 1;
    tick;
    chk("sw_mask", mip_q, 12'h133);
    chk("wfi_on", wfi_wake, 1);
    tick;
    chk("wfi_novalid", int_valid, 0);
    csr_mie.ssip = 0;
    #1;
    chk("wfi_off", wfi_wake, 0);

    // user-level priority UEI > USI > UTI
    do_reset;
    prv = 0;
    csr_mip_sw.ueip = 1; csr_mip_sw.usip = 1; csr_mip_sw.utip = 1;
    csr_mie.ueip = 1; csr_mie.usip = 1; csr_mie.utip = 1;
    csr_mideleg.ueip = 1; csr_mideleg.usip = 1;
    csr_mideleg.utip = 1;
    tick; tick;
    chk("uei_cause", int_cause, ORV64_INT_U_EXT);
    int_ready = 1; csr_mie.ueip = 0;
    tick;
    int_ready = 0;
    tick; tick;
    chk("usi_valid", int_valid, 1);
    chk("usi_cause", int_cause, ORV64_INT_U_SW);

    // MSI beats MTI
    do_reset;
    prv = 0; ext_msip = 1; ext_mtip = 1;
    csr_mie.msip = 1; csr_mie.mtip = 1;
    repeat (LAT + 1) tick;
    chk("msi_cause", int_cause, ORV64_INT_M_SW);

    // one-cycle pulse on ext_mtip reaches mip_q after LAT edges
    do_reset;
    ext_mtip = 1;
    tick;
    ext_mtip = 0;
    for (int e = 1; e <= LAT + 1; e++) begin
      if (e > 1) tick;
      chk($sformatf("pulse_e%0d", e), mip_q.mtip, (e == LAT));
    end

    // async reset mid-REQ
    do_reset;
    prv = 3; mstatus_mie = 1; csr_mie.meip = 1; ext_meip = 1;
    repeat (LAT + 1) tick;
    chk("ar_pre", int_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", int_valid, 0);
    chk("ar_mip", mip_q, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/orv64_int_req_gen.md
ORV64_INT_REQ_GEN -- requirements
Module: orv64_int_req_gen

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, synchronizer depth for asynchronous interrupt inputs (legal 2..4).
REQ-002 SHALL have ports: one clock, reset asynchronous and active-low, named as below.
REQ-003 clk  input  1  core clock; all state on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 ext_meip, ext_mtip, ext_msip, ext_seip  input  1 each  level interrupt lines from PLIC/CLINT, asynchronous to clk.
REQ-006 csr_mip_sw  input  orv64_csr_ideleg_t  software-writable pending bits (ssip, stip, usip, utip, ueip); synchronous.
REQ-007 csr_mie  input  orv64_csr_ideleg_t  per-interrupt enables.
REQ-008 csr_mideleg  input  orv64_csr_ideleg_t  delegation to S-mode.
REQ-009 prv  input  2  current privilege (0=U, 1=S, 3=M).
REQ-010 mstatus_mie, mstatus_sie  input  1 each  global enables.
REQ-011 int_ready  input  1  pipeline accepts the interrupt (commit point).
REQ-012 int_valid  output  1  interrupt request to pipeline/delegation logic.
REQ-013 int_cause  output  orv64_int_cause_t  cause of the request.
REQ-014 mip_q  output  orv64_csr_ideleg_t  registered pending vector for CSR mip reads.
REQ-015 wfi_wake  output  1  any pending & enabled bit, ignoring global enables and privilege.

Function
REQ-016 Pending vector SHALL be registered: hardware bits (meip, mtip, msip, seip) via sync path (Configuration), software bits via one flop; all other bits of mip_q SHALL be 0.
REQ-017 Bit i eligible when mip_q[i] & csr_mie[i] & target enable; target M if csr_mideleg[i]=0, else S.
REQ-018 M-target enable: prv!=3, or prv==3 & mstatus_mie; S-target enable: prv==0, or prv==1 & mstatus_sie; S-target never eligible at prv==3.
REQ-019 Fixed priority among eligible bits: MEI > MSI > MTI > SEI > SSI > STI > UEI > USI > UTI.
REQ-020 FSM states IDLE, REQ, ACK; IDLE->REQ when any bit eligible, registering int_valid=1 and int_cause=winner on that edge.
REQ-021 In REQ, int_cause SHALL remain stable; a higher-priority arrival SHALL NOT change it.
REQ-022 REQ->ACK on int_valid & int_ready; int_valid deasserts on that edge.
REQ-023 REQ->IDLE (withdraw, int_valid=0) when latched cause loses eligibility and int_ready=0; int_ready=1 in same cycle SHALL take priority (handshake completes).
REQ-024 ACK SHALL last exactly one cycle (no request), then IDLE, letting CSR/privilege updates settle; re-arbitration occurs from IDLE.
REQ-025 wfi_wake SHALL be combinational from mip_q & csr_mie.

Reset
REQ-026 On rstn=0: FSM=IDLE, int_valid=0, int_cause=ORV64_INT_U_SW, mip_q=0, all synchronizer flops=0, wfi_wake=0.
REQ-027 Reset asserted mid-REQ SHALL drop int_valid immediately (asynchronous); first request after release no earlier than 2 edges (SYNC_STAGES+1 with macro).

Configuration
REQ-028 Macro ORV64_INT_SYNC_EN defined: hardware inputs pass SYNC_STAGES flop chain; ext-to-int_valid latency SYNC_STAGES+1 edges.
REQ-029 Macro undefined: hardware inputs take single flop like software bits; latency 2 edges; SYNC_STAGES ignored.

Structure
REQ-030 orv64_int_cause_t, orv64_csr_ideleg_t, priority order and FSM state enum SHALL live in orv64_typedef_pkg.
REQ-031 Synchronizer SHALL be a sub-module orv64_int_sync (parameter SYNC_STAGES, width 1), instantiated per hardware line only under ORV64_INT_SYNC_EN.

Verification
REQ-032 No macro, prv=3, mstatus_mie=1, mie.meip=1, ext_meip 0->1 before edge 1 -> int_valid=1, int_cause=ORV64_INT_M_EXT after edge 2.
REQ-033 mip mtip+seip pending, both enabled, mideleg.seip=1, prv=0 -> int_cause=ORV64_INT_M_TIME; after handshake + ACK cycle, then ORV64_INT_S_EXT.
REQ-034 REQ with ORV64_INT_S_SW, int_ready=0, mstatus_sie 1->0 at prv=1 -> int_valid=0 next edge, FSM IDLE.
REQ-035 REQ with S_SW pending, ext_meip rises, int_ready held 0 -> int_cause stays ORV64_INT_S_SW until accept.
REQ-036 Macro defined, SYNC_STAGES=3: ext_mtip pulse 1->0 after 1 cycle -> mip_q.mtip high for 1 cycle, 3 edges after input.
REQ-037 rstn low during REQ -> int_valid=0 without clock edge; mip_q=0.
